// File: rtl/noc_injector.sv
// Client-to-router injection stage: local flit FIFO, credit flow control,
// and per-packet destination latching from the head flit.
module noc_injector #(
    parameter int DEST_WIDTH        = 1,
    parameter int FLIT_WIDTH        = 32,
    parameter int FLIT_BUFFER_DEPTH = 4,
    parameter int INPUT_FIFO_DEPTH  = 4,
    localparam int CW = $clog2(FLIT_BUFFER_DEPTH + 1),
    localparam int AW = $clog2(INPUT_FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [FLIT_WIDTH-1:0] s_data,
    input  logic [DEST_WIDTH-1:0] s_dest,
    input  logic                  s_last,
    output logic                  send_out,
    output logic [FLIT_WIDTH-1:0] data_out,
    output logic [DEST_WIDTH-1:0] dest_out,
    output logic                  is_tail_out,
    input  logic                  credit_in,
    output logic [CW-1:0]         credit_count,
    output logic                  err_credit_overflow,
    output logic                  idle
);

    localparam int EW = FLIT_WIDTH + DEST_WIDTH + 1;
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CRED_ONE = CW'(1);
    localparam logic [CW-1:0] CRED_MAX = CW'(FLIT_BUFFER_DEPTH);

    typedef enum logic {HEAD, BODY} state_t;

    logic [EW-1:0]         mem [INPUT_FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [EW-1:0]         head;
    logic [FLIT_WIDTH-1:0] head_data;
    logic [DEST_WIDTH-1:0] head_dest;
    logic                  head_last;
    logic [DEST_WIDTH-1:0] cur_dest;
    state_t                state;
    logic                  empty;
    logic                  full;
    logic                  push;
    logic                  fire;

    // Extra pointer bit distinguishes full from empty when indices match.
    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign s_ready = !full;
    assign push    = s_valid && !full;
    assign fire    = !empty && (credit_count != '0);

    assign head      = mem[rd_ptr[AW-1:0]];
    assign head_data = head[EW-1:DEST_WIDTH+1];
    assign head_dest = head[DEST_WIDTH:1];
    assign head_last = head[0];

    assign idle = empty && (state == HEAD) && (credit_count == CRED_MAX);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {s_data, s_dest, s_last};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr              <= '0;
            rd_ptr              <= '0;
            state               <= HEAD;
            cur_dest            <= '0;
            send_out            <= 1'b0;
            data_out            <= '0;
            dest_out            <= '0;
            is_tail_out         <= 1'b0;
            credit_count        <= CRED_MAX;
            err_credit_overflow <= 1'b0;
        end else begin
            send_out <= fire;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (fire) begin
                rd_ptr      <= rd_ptr + PTR_ONE;
                data_out    <= head_data;
                is_tail_out <= head_last;
                if (state == HEAD) begin
                    dest_out <= head_dest;
                    cur_dest <= head_dest;
                    if (!head_last) begin
                        state <= BODY;
                    end
                end else begin
                    dest_out <= cur_dest;
                    if (head_last) begin
                        state <= HEAD;
                    end
                end
            end
            unique case ({fire, credit_in})
                2'b10: credit_count <= credit_count - CRED_ONE;
                2'b01: begin
                    if (credit_count == CRED_MAX) begin
                        err_credit_overflow <= 1'b1;
                    end else begin
                        credit_count <= credit_count + CRED_ONE;
                    end
                end
                default: credit_count <= credit_count;
            endcase
        end
    end

endmodule

// File: tb/tb_noc_injector.sv
// Scoreboard bench for noc_injector: expected flits queued on accept,
// popped and compared when the router-side send pulse appears.
module tb_noc_injector;

    logic        clk;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        s_dest;
    logic        s_last;
    logic        send_out;
    logic [31:0] data_out;
    logic        dest_out;
    logic        is_tail_out;
    logic        credit_in;
    logic [2:0]  credit_count;
    logic        err_credit_overflow;
    logic        idle;

    logic        loopback;
    logic        cred_manual;

    int n_cmp;
    int n_err;
    int n_sent;

    logic [33:0] exp_q[$];
    logic        in_body;
    logic        pkt_dest;

    assign credit_in = loopback ? send_out : cred_manual;

    noc_injector dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .s_valid             (s_valid),
        .s_ready             (s_ready),
        .s_data              (s_data),
        .s_dest              (s_dest),
        .s_last              (s_last),
        .send_out            (send_out),
        .data_out            (data_out),
        .dest_out            (dest_out),
        .is_tail_out         (is_tail_out),
        .credit_in           (credit_in),
        .credit_count        (credit_count),
        .err_credit_overflow (err_credit_overflow),
        .idle                (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        logic [33:0] e;
        if (rst_n && send_out) begin
            n_sent++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_send data=%h dest=%b tail=%b",
                         data_out, dest_out, is_tail_out);
            end else begin
                e = exp_q.pop_front();
                if ({data_out, dest_out, is_tail_out} !== e) begin
                    n_err++;
                    $display("FAIL flit got data=%h dest=%b tail=%b want data=%h dest=%b tail=%b",
                             data_out, dest_out, is_tail_out, e[33:2], e[1], e[0]);
                end
            end
        end
    end

    task automatic push(input logic [31:0] d, input logic dst, input logic lst);
        int w;
        s_valid = 1'b1;
        s_data  = d;
        s_dest  = dst;
        s_last  = lst;
        w = 0;
        while (!s_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!s_ready) begin
            s_valid = 1'b0;
            n_cmp++;
            n_err++;
            $display("FAIL push_timeout s_ready=%b want 1", s_ready);
        end else begin
            if (!in_body) pkt_dest = dst;
            exp_q.push_back({d, pkt_dest, lst});
            in_body = !lst;
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({credit_count, send_out, s_ready, idle, err_credit_overflow} !== {3'd4, 1'b0, 1'b1, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL reset_state got cred=%0d send=%b rdy=%b idle=%b err=%b want 4 0 1 1 0",
                     credit_count, send_out, s_ready, idle, err_credit_overflow);
        end
        n_cmp++;
        if ({data_out, dest_out, is_tail_out} !== 34'd0) begin
            n_err++;
            $display("FAIL reset_outputs got data=%h dest=%b tail=%b want 0",
                     data_out, dest_out, is_tail_out);
        end
    endtask

    task automatic test_single();
        int base;
        base = n_sent;
        loopback = 1'b1;
        push(32'h1, 1'b1, 1'b1);
        wait_drain();
        n_cmp++;
        if (n_sent - base !== 1) begin
            n_err++;
            $display("FAIL single_count got %0d want 1", n_sent - base);
        end
        n_cmp++;
        if ({credit_count, idle} !== {3'd4, 1'b1}) begin
            n_err++;
            $display("FAIL single_idle got cred=%0d idle=%b want 4 1", credit_count, idle);
        end
    endtask

    task automatic test_credit_stall();
        int base;
        base = n_sent;
        loopback = 1'b0;
        cred_manual = 1'b0;
        for (int i = 1; i <= 6; i++) push(32'(i), 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        n_cmp++;
        if ({n_sent - base, credit_count, exp_q.size(), send_out} !== {32'd4, 3'd0, 32'd2, 1'b0}) begin
            n_err++;
            $display("FAIL stall got sent=%0d cred=%0d queued=%0d want 4 0 2",
                     n_sent - base, credit_count, exp_q.size());
        end
        cred_manual = 1'b1;
        @(negedge clk);
        cred_manual = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({n_sent - base, credit_count, exp_q.size()} !== {32'd5, 3'd0, 32'd1}) begin
            n_err++;
            $display("FAIL stall_pulse got sent=%0d cred=%0d queued=%0d want 5 0 1",
                     n_sent - base, credit_count, exp_q.size());
        end
        cred_manual = 1'b1;
        repeat (5) @(negedge clk);
        cred_manual = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({n_sent - base, credit_count, idle, err_credit_overflow} !== {32'd6, 3'd4, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL stall_recover got sent=%0d cred=%0d idle=%b err=%b want 6 4 1 0",
                     n_sent - base, credit_count, idle, err_credit_overflow);
        end
    endtask

    task automatic test_dest_latch();
        loopback = 1'b1;
        push(32'hA, 1'b0, 1'b0);
        push(32'hB, 1'b1, 1'b0);
        push(32'hC, 1'b1, 1'b1);
        push(32'hD, 1'b1, 1'b1);
        wait_drain();
        n_cmp++;
        if ({exp_q.size(), idle} !== {32'd0, 1'b1}) begin
            n_err++;
            $display("FAIL dest_drain got queued=%0d idle=%b want 0 1", exp_q.size(), idle);
        end
    endtask

    task automatic test_back_pressure();
        int base;
        int acc;
        base = n_sent;
        acc = 0;
        loopback = 1'b0;
        cred_manual = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (!s_ready) break;
            push(32'h100 + 32'(i), 1'b1, 1'b1);
            acc++;
        end
        n_cmp++;
        if ({acc, s_ready} !== {32'd8, 1'b0}) begin
            n_err++;
            $display("FAIL bp_fill got accepted=%0d rdy=%b want 8 0", acc, s_ready);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (n_sent - base !== 4) begin
            n_err++;
            $display("FAIL bp_inflight got %0d want 4", n_sent - base);
        end
        cred_manual = 1'b1;
        repeat (8) @(negedge clk);
        cred_manual = 1'b0;
        wait_drain();
        n_cmp++;
        if ({n_sent - base, exp_q.size(), credit_count, idle} !== {32'd8, 32'd0, 3'd4, 1'b1}) begin
            n_err++;
            $display("FAIL bp_drain got sent=%0d queued=%0d cred=%0d idle=%b want 8 0 4 1",
                     n_sent - base, exp_q.size(), credit_count, idle);
        end
    endtask

    task automatic test_overflow_reset();
        loopback = 1'b0;
        cred_manual = 1'b1;
        @(negedge clk);
        cred_manual = 1'b0;
        n_cmp++;
        if ({err_credit_overflow, credit_count} !== {1'b1, 3'd4}) begin
            n_err++;
            $display("FAIL overflow got err=%b cred=%0d want 1 4", err_credit_overflow, credit_count);
        end
        loopback = 1'b1;
        push(32'h11, 1'b1, 1'b0);
        rst_n = 1'b0;
        exp_q.delete();
        in_body = 1'b0;
        #1;
        n_cmp++;
        if ({send_out, data_out, dest_out, is_tail_out, err_credit_overflow, credit_count, idle, s_ready}
            !== {1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL midpkt_reset got send=%b data=%h dest=%b tail=%b err=%b cred=%0d idle=%b rdy=%b",
                     send_out, data_out, dest_out, is_tail_out, err_credit_overflow,
                     credit_count, idle, s_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push(32'h21, 1'b0, 1'b0);
        push(32'h22, 1'b1, 1'b1);
        wait_drain();
        n_cmp++;
        if ({exp_q.size(), idle, err_credit_overflow} !== {32'd0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL post_reset got queued=%0d idle=%b err=%b want 0 1 0",
                     exp_q.size(), idle, err_credit_overflow);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        n_sent = 0;
        in_body = 1'b0;
        pkt_dest = 1'b0;
        rst_n = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        s_dest = 1'b0;
        s_last = 1'b0;
        loopback = 1'b0;
        cred_manual = 1'b0;
        test_reset();
        test_single();
        test_credit_stall();
        test_dest_latch();
        test_back_pressure();
        test_overflow_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
